// File: rtl/frost32_fetch_unit_pkg.sv
// Shared types and instruction predecode for the Frost32 fetch stage.
// Per-entry predecode storage exists only when FROST32_FETCH_PREDECODE_EN is defined.
package frost32_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // Instruction field layout shared with the decoder.
  localparam int GROUP_MSB  = 31;
  localparam int GROUP_LSB  = 28;
  localparam int OPCODE_MSB = 3;
  localparam int OPCODE_LSB = 0;
  localparam int FILL_MSB   = 15;
  localparam int FILL_LSB   = 4;

  typedef enum logic [3:0] {
    GRP_ALU    = 4'd0,
    GRP_LDST   = 4'd1,
    GRP_BRANCH = 4'd2,
    GRP_SYSTEM = 4'd3
  } instr_group_e;

  localparam logic [3:0] ALU_OP_LIMIT    = 4'd12;
  localparam logic [3:0] BRANCH_OP_LIMIT = 4'd4;
  localparam logic [3:0] SYSTEM_OP_LIMIT = 4'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
`ifdef FROST32_FETCH_PREDECODE_EN
    logic        bad;
`endif
  } fetch_entry_t;

  // Flags words the decoder would reject, so the check is off the decode path.
  function automatic logic predecode_bad(input logic [31:0] instr);
    logic [3:0] group;
    logic [3:0] opcode;
    logic       fill_nz;
    group   = instr[GROUP_MSB:GROUP_LSB];
    opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    fill_nz = |instr[FILL_MSB:FILL_LSB];
    case (group)
      GRP_ALU:    predecode_bad = (opcode >= ALU_OP_LIMIT) || fill_nz;
      GRP_LDST:   predecode_bad = 1'b0;
      GRP_BRANCH: predecode_bad = (opcode >= BRANCH_OP_LIMIT) || fill_nz;
      GRP_SYSTEM: predecode_bad = (opcode >= SYSTEM_OP_LIMIT) || fill_nz;
      default:    predecode_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/frost32_fetch_unit_fifo.sv
// Prefetch FIFO of fetch entries with push, pop and flush.
// Flush has priority over push and pop in the same cycle.
module frost32_fetch_fifo
  import frost32_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is reset here only because the head drives out_* directly and must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/frost32_fetch_unit.sv
// Frost32 instruction fetch: one-outstanding reads, prefetch FIFO, redirect flush.
// Optional predecode of illegal words: FROST32_FETCH_PREDECODE_EN.
module frost32_fetch_unit
  import frost32_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        in_redirect_valid,
  input  logic [31:0] in_redirect_pc,
  input  logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_bad_instr
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   stale_addr_q;
  logic [31:0]   redirect_target;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          space_after;

  assign redirect_target = in_redirect_pc & ~32'd3;
  assign push        = (state_q == FETCH) && mem_ack && !in_redirect_valid;
  assign pop         = !fifo_empty && in_ready && !in_redirect_valid;
  assign count_after = fifo_count + CW'(push) - CW'(pop);
  assign space_after = count_after < CW'(FIFO_DEPTH);

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = mem_rdata;
`ifdef FROST32_FETCH_PREDECODE_EN
    push_entry.bad   = predecode_bad(mem_rdata);
`endif
  end

  frost32_fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (in_redirect_valid),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // NOTE: state_d is defaulted first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_redirect_valid || !fifo_full) state_d = FETCH;
      end
      FETCH: begin
        if (in_redirect_valid)  state_d = mem_ack ? FETCH : DISCARD;
        else if (mem_ack)       state_d = space_after ? FETCH : IDLE;
      end
      DISCARD: begin
        // The stale read must retire before the new target can be requested.
        if (mem_ack) state_d = (in_redirect_valid || space_after) ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      stale_addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (in_redirect_valid)  fetch_pc_q <= redirect_target;
      else if (push)          fetch_pc_q <= fetch_pc_q + 32'd4;
      if (state_q == FETCH && in_redirect_valid && !mem_ack) stale_addr_q <= fetch_pc_q;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = (state_q == DISCARD) ? stale_addr_q : fetch_pc_q;
  assign out_valid = !fifo_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
`ifdef FROST32_FETCH_PREDECODE_EN
  assign out_bad_instr = head.bad;
`else
  assign out_bad_instr = 1'b0;
`endif

endmodule

// File: tb/tb_frost32_fetch_unit.sv
// Directed testbench for frost32_fetch_unit: vector table plus reset and wrap sequences.
module tb_frost32_fetch_unit;

`ifdef FROST32_FETCH_PREDECODE_EN
  localparam bit BAD_EN = 1'b1;
`else
  localparam bit BAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        mem_req, mem_ack, out_valid, out_bad_instr;
  logic [31:0] mem_addr, mem_rdata, out_instr, out_pc;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        in_ready = 1'b0;
  logic        auto_ack = 1'b0;
  logic        man_ack = 1'b0;

  // Wrap instance: always-ready decoder, zero-wait memory
  logic        w_req, w_ack, w_valid, w_bad;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h300: word_at = 32'h0000_000C;
      32'h304: word_at = 32'h1120_0005;
      32'h308: word_at = 32'h5000_0000;
      default: word_at = 32'h1000_0000 | {4'h0, a[27:0]};
    endcase
  endfunction

  assign mem_ack   = auto_ack ? mem_req : man_ack;
  assign mem_rdata = word_at(mem_addr);
  assign w_ack     = w_req;
  assign w_rdata   = word_at(w_addr);

  frost32_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .in_redirect_valid(redir_valid), .in_redirect_pc(redir_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_bad_instr(out_bad_instr)
  );

  frost32_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
    .in_redirect_valid(1'b0), .in_redirect_pc(32'h0), .in_ready(1'b1),
    .out_valid(w_valid), .out_instr(w_instr), .out_pc(w_pc), .out_bad_instr(w_bad)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          aack;
    bit          mack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    bit          e_bad;
  } vec_t;

  function automatic vec_t mk(bit ready, bit redir, logic [31:0] rpc, bit aack, bit mack,
                              bit e_req, logic [31:0] e_addr, bit e_valid,
                              logic [31:0] e_pc, logic [31:0] e_instr, bit e_bad);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc; v.aack = aack; v.mack = mack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_bad = e_bad;
    return v;
  endfunction

  vec_t vecs [22];

  task automatic check_reset(input string tag);
    check({tag, ".mem_req"},   32'(mem_req),       32'd0);
    check({tag, ".mem_addr"},  mem_addr,           32'h0);
    check({tag, ".out_valid"}, 32'(out_valid),     32'd0);
    check({tag, ".out_instr"}, out_instr,          32'h0);
    check({tag, ".out_pc"},    out_pc,             32'h0);
    check({tag, ".out_bad"},   32'(out_bad_instr), 32'd0);
  endtask

  initial begin
    // inputs of cycle i, expected registered outputs seen during cycle i
    vecs[0]  = mk(1, 0, 0,      1, 0,  1, 32'h000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,      1, 0,  1, 32'h004, 1, 32'h000, 32'h1000_0000, 0);
    vecs[2]  = mk(0, 0, 0,      1, 0,  1, 32'h008, 1, 32'h004, 32'h1000_0004, 0);
    vecs[3]  = mk(0, 0, 0,      1, 0,  0, 0,       1, 32'h004, 32'h1000_0004, 0);
    vecs[4]  = mk(1, 0, 0,      1, 0,  0, 0,       1, 32'h004, 32'h1000_0004, 0);
    vecs[5]  = mk(0, 0, 0,      1, 0,  0, 0,       1, 32'h008, 32'h1000_0008, 0);
    vecs[6]  = mk(0, 0, 0,      1, 0,  1, 32'h00C, 1, 32'h008, 32'h1000_0008, 0);
    vecs[7]  = mk(1, 0, 0,      1, 0,  0, 0,       1, 32'h008, 32'h1000_0008, 0);
    vecs[8]  = mk(1, 0, 0,      1, 0,  0, 0,       1, 32'h00C, 32'h1000_000C, 0);
    vecs[9]  = mk(1, 0, 0,      1, 0,  1, 32'h010, 0, 0, 0, 0);
    vecs[10] = mk(1, 0, 0,      1, 0,  1, 32'h014, 1, 32'h010, 32'h1000_0010, 0);
    vecs[11] = mk(1, 1, 32'h203, 1, 0, 1, 32'h018, 1, 32'h014, 32'h1000_0014, 0);
    vecs[12] = mk(1, 0, 0,      1, 0,  1, 32'h200, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0,      0, 0,  1, 32'h204, 1, 32'h200, 32'h1000_0200, 0);
    vecs[14] = mk(1, 1, 32'h100, 0, 0, 1, 32'h204, 0, 0, 0, 0);
    vecs[15] = mk(1, 1, 32'h300, 0, 0, 1, 32'h204, 0, 0, 0, 0);
    vecs[16] = mk(1, 0, 0,      0, 1,  1, 32'h204, 0, 0, 0, 0);
    vecs[17] = mk(1, 0, 0,      1, 0,  1, 32'h300, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 0,      1, 0,  1, 32'h304, 1, 32'h300, 32'h0000_000C, BAD_EN);
    vecs[19] = mk(1, 0, 0,      1, 0,  1, 32'h308, 1, 32'h304, 32'h1120_0005, 0);
    vecs[20] = mk(1, 0, 0,      1, 0,  1, 32'h30C, 1, 32'h308, 32'h5000_0000, BAD_EN);
    vecs[21] = mk(1, 0, 0,      1, 0,  1, 32'h310, 1, 32'h30C, 32'h1000_030C, 0);

    // Reset state
    @(negedge clk);
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    check("release.mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      in_ready    = vecs[i].ready;
      redir_valid = vecs[i].redir;
      redir_pc    = vecs[i].rpc;
      auto_ack    = vecs[i].aack;
      man_ack     = vecs[i].mack;
      check($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        check($sformatf("v%0d.out_pc", i), out_pc, vecs[i].e_pc);
        check($sformatf("v%0d.out_instr", i), out_instr, vecs[i].e_instr);
        check($sformatf("v%0d.out_bad", i), 32'(out_bad_instr), 32'(vecs[i].e_bad));
      end
      if (i == 0) check("wrap.first_addr", w_addr, 32'hFFFF_FFFC);
      if (i == 1) begin
        check("wrap.second_addr", w_addr, 32'h0000_0000);
        check("wrap.first_pc", w_pc, 32'hFFFF_FFFC);
      end
      @(negedge clk);
    end

    // Reset asserted while a read of 0x314 is outstanding
    redir_valid = 1'b0;
    auto_ack    = 1'b0;
    man_ack     = 1'b0;
    in_ready    = 1'b0;
    @(negedge clk);
    check("midread.mem_req", 32'(mem_req), 32'd1);
    check("midread.mem_addr", mem_addr, 32'h314);
    rst_n = 1'b0;
    #1;
    check_reset("midreset");
    man_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("rerelease.mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    // ack during the IDLE cycle must not have pushed anything
    check("idle_ack.out_valid", 32'(out_valid), 32'd0);
    check("idle_ack.mem_req", 32'(mem_req), 32'd1);
    check("idle_ack.mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    check("refetch.out_valid", 32'(out_valid), 32'd1);
    check("refetch.out_pc", out_pc, 32'h0);
    check("refetch.out_instr", out_instr, 32'h1000_0000);
    check("refetch.mem_addr", mem_addr, 32'h4);
    man_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
